// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings for the fetch stage.
// FSM states, MEM_PCSrc codes and the default bubble word.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_STALL    = 2'b01,
      ST_REDIRECT = 2'b10
   } fetch_state_e;

   typedef enum logic [1:0] {
      SRC_SEQ = 2'b00,
      SRC_BR  = 2'b01,
      SRC_JMP = 2'b10,
      SRC_JR  = 2'b11
   } pcsrc_e;

   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: 65-bit IF/ID register {instr, pcplus4, valid}.
// bubble wins over hold; reset loads a bubble.
import fetch_pkg::*;

module if_id_reg #(
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_hold,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pcplus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pcplus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pcplus4;
   logic        r_valid;

   // Load bubble, hold, or capture the fetched word each edge.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_bubble) begin
         r_instr   <= NOP_WORD;
         r_pcplus4 <= 32'd0;
         r_valid   <= 1'b0;
      end else if (!i_hold) begin
         r_instr   <= i_instr;
         r_pcplus4 <= i_pcplus4;
         r_valid   <= 1'b1;
      end
   end

   assign o_instr   = r_instr;
   assign o_pcplus4 = r_pcplus4;
   assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register, redirect mux, fetch FSM.
// Optional perf counters under FETCH_PERF_EN.
import fetch_pkg::*;

module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ID_Stall,
   input  logic        Flush_IF_ID,
   input  logic [1:0]  MEM_PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] JrTarget,
   input  logic [31:0] IM_Instruction,
   output logic [31:0] IF_PC,
   output logic [31:0] ID_Instruction,
   output logic [31:0] ID_PCPlus4,
   output logic        ID_Valid,
   output logic [1:0]  FetchState
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCycles
`endif
);

   fetch_state_e r_state;
   fetch_state_e w_next_state;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_target;
   logic [31:0]  w_next_pc;
   logic         w_redirect;
   logic         w_bubble;
   logic         w_hold;
   logic         w_stall_taken;

   assign w_pc_plus4 = r_pc + PC_STEP;
   assign w_redirect = (MEM_PCSrc != SRC_SEQ);

   // Select the redirect target, word-aligned.
   always_comb begin
      w_target = 32'd0;
      unique case (pcsrc_e'(MEM_PCSrc))
         SRC_BR:  w_target = BranchTarget;
         SRC_JMP: w_target = JumpTarget;
         SRC_JR:  w_target = JrTarget;
         default: w_target = 32'd0;
      endcase
      w_target[1:0] = 2'b00;
   end

   // Priority: redirect > flush > stall > sequential.
   always_comb begin
      w_next_state  = ST_RUN;
      w_next_pc     = w_pc_plus4;
      w_bubble      = 1'b0;
      w_hold        = 1'b0;
      w_stall_taken = 1'b0;
      if (w_redirect) begin
         w_next_state = ST_REDIRECT;
         w_next_pc    = w_target;
         w_bubble     = 1'b1;
      end else if (Flush_IF_ID) begin
         w_bubble = 1'b1;
         if (ID_Stall) begin
            w_next_state  = ST_STALL;
            w_next_pc     = r_pc;
            w_stall_taken = 1'b1;
         end
      end else if (ID_Stall) begin
         w_next_state  = ST_STALL;
         w_next_pc     = r_pc;
         w_hold        = 1'b1;
         w_stall_taken = 1'b1;
      end
   end

   // PC and FSM state registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc    <= RESET_PC;
         r_state <= ST_RUN;
      end else begin
         r_pc    <= w_next_pc;
         r_state <= w_next_state;
      end
   end

   if_id_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id (
      .i_clk     (Clk),
      .i_rst     (Reset),
      .i_hold    (w_hold),
      .i_bubble  (w_bubble),
      .i_instr   (IM_Instruction),
      .i_pcplus4 (w_pc_plus4),
      .o_instr   (ID_Instruction),
      .o_pcplus4 (ID_PCPlus4),
      .o_valid   (ID_Valid)
   );

   assign IF_PC      = r_pc;
   assign FetchState = r_state;

`ifdef FETCH_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Saturating stall/bubble cycle counters.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (w_stall_taken && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_bubble && (r_flush_cnt != 32'hFFFF_FFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign StallCycles = r_stall_cnt;
   assign FlushCycles = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: directed bench for fetch_stage_ctrl.
// Perf counter checks compile in with FETCH_PERF_EN.
module tb_fetch_stage_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        ID_Stall;
   logic        Flush_IF_ID;
   logic [1:0]  MEM_PCSrc;
   logic [31:0] BranchTarget;
   logic [31:0] JumpTarget;
   logic [31:0] JrTarget;
   logic [31:0] IM_Instruction;
   logic [31:0] IF_PC;
   logic [31:0] ID_Instruction;
   logic [31:0] ID_PCPlus4;
   logic        ID_Valid;
   logic [1:0]  FetchState;
`ifdef FETCH_PERF_EN
   logic [31:0] StallCycles;
   logic [31:0] FlushCycles;
`endif

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   assign IM_Instruction = 32'h1111_0000 + IF_PC;

   fetch_stage_ctrl dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ID_Stall       (ID_Stall),
      .Flush_IF_ID    (Flush_IF_ID),
      .MEM_PCSrc      (MEM_PCSrc),
      .BranchTarget   (BranchTarget),
      .JumpTarget     (JumpTarget),
      .JrTarget       (JrTarget),
      .IM_Instruction (IM_Instruction),
      .IF_PC          (IF_PC),
      .ID_Instruction (ID_Instruction),
      .ID_PCPlus4     (ID_PCPlus4),
      .ID_Valid       (ID_Valid),
      .FetchState     (FetchState)
`ifdef FETCH_PERF_EN
      ,
      .StallCycles    (StallCycles),
      .FlushCycles    (FlushCycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] p4,
                         input logic vld, input logic [1:0] st);
      chk({tag, ".pc"}, IF_PC, pc);
      chk({tag, ".ins"}, ID_Instruction, ins);
      chk({tag, ".p4"}, ID_PCPlus4, p4);
      chk({tag, ".vld"}, {31'd0, ID_Valid}, {31'd0, vld});
      chk({tag, ".st"}, {30'd0, FetchState}, {30'd0, st});
   endtask

   initial begin
      Reset        = 1'b1;
      ID_Stall     = 1'b0;
      Flush_IF_ID  = 1'b0;
      MEM_PCSrc    = 2'b00;
      BranchTarget = 32'h0;
      JumpTarget   = 32'h0;
      JrTarget     = 32'h0;

      step();
      chk_st("rst", 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
`ifdef FETCH_PERF_EN
      chk("rst.scnt", StallCycles, 32'd0);
      chk("rst.fcnt", FlushCycles, 32'd0);
`endif
      Reset = 1'b0;

      step();
      chk_st("run1", 32'h4, 32'h1111_0000, 32'h4, 1'b1, 2'b00);
      step();
      chk_st("run2", 32'h8, 32'h1111_0004, 32'h8, 1'b1, 2'b00);
      step();
      chk_st("run3", 32'hC, 32'h1111_0008, 32'hC, 1'b1, 2'b00);

      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      step();
      chk_st("pre_stall", 32'h8, 32'h1111_0004, 32'h8, 1'b1, 2'b00);

      ID_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_st("stall", 32'h8, 32'h1111_0004, 32'h8, 1'b1, 2'b01);
      end
      ID_Stall = 1'b0;
      step();
      chk_st("release", 32'hC, 32'h1111_0008, 32'hC, 1'b1, 2'b00);
`ifdef FETCH_PERF_EN
      chk("scnt3", StallCycles, 32'd3);
      chk("fcnt0", FlushCycles, 32'd0);
`endif

      ID_Stall    = 1'b1;
      Flush_IF_ID = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk_st("stflush", 32'hC, 32'h0, 32'h0, 1'b0, 2'b01);
      end
`ifdef FETCH_PERF_EN
      chk("fcnt2", FlushCycles, 32'd2);
      chk("scnt5", StallCycles, 32'd5);
`endif

      Flush_IF_ID  = 1'b0;
      MEM_PCSrc    = 2'b01;
      BranchTarget = 32'h40;
      step();
      chk_st("br", 32'h40, 32'h0, 32'h0, 1'b0, 2'b10);
`ifdef FETCH_PERF_EN
      chk("fcnt3", FlushCycles, 32'd3);
      chk("scnt5b", StallCycles, 32'd5);
`endif
      ID_Stall  = 1'b0;
      MEM_PCSrc = 2'b00;
      step();
      chk_st("br_next", 32'h44, 32'h1111_0040, 32'h44, 1'b1, 2'b00);

      MEM_PCSrc = 2'b11;
      JrTarget  = 32'h0000_0103;
      step();
      chk_st("jr", 32'h100, 32'h0, 32'h0, 1'b0, 2'b10);

      MEM_PCSrc  = 2'b10;
      JumpTarget = 32'hFFFF_FFFE;
      step();
      chk_st("jmp_b2b", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 2'b10);

      MEM_PCSrc = 2'b00;
      step();
      chk_st("wrap", 32'h0, 32'h1110_FFFC, 32'h0, 1'b1, 2'b00);

      MEM_PCSrc    = 2'b01;
      BranchTarget = 32'h80;
      step();
      chk_st("br80", 32'h80, 32'h0, 32'h0, 1'b0, 2'b10);
      Reset = 1'b1;
      step();
      chk_st("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
`ifdef FETCH_PERF_EN
      chk("rst.fcnt2", FlushCycles, 32'd0);
`endif
      Reset     = 1'b0;
      MEM_PCSrc = 2'b00;
      step();
      chk_st("post_rst", 32'h4, 32'h1111_0000, 32'h4, 1'b1, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Fetch-side responder to the hazard detection unit. Owns the PC register and the IF/ID pipeline register and obeys `ID_Stall`, `Flush_IF_ID` and `MEM_PCSrc` redirects, issuing one instruction per cycle otherwise. Sits between instruction memory and the ID stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_WORD`, 32'h0000_0000, instruction word inserted as a bubble
- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `ID_Stall`  in  1  hold PC and IF/ID contents
- `Flush_IF_ID`  in  1  replace IF/ID contents with a bubble
- `MEM_PCSrc`  in  2  00 sequential, 01 branch, 10 jump, 11 JR
- `BranchTarget`  in  32  branch target address, used when `MEM_PCSrc`=01
- `JumpTarget`  in  32  jump target address, used when `MEM_PCSrc`=10
- `JrTarget`  in  32  register target address, used when `MEM_PCSrc`=11
- `IM_Instruction`  in  32  instruction memory read data for `IF_PC`, combinational
- `IF_PC`  out  32  registered fetch address to instruction memory
- `ID_Instruction`  out  32  IF/ID instruction
- `ID_PCPlus4`  out  32  IF/ID PC+4
- `ID_Valid`  out  1  1 = real instruction; 0 = bubble
- `FetchState`  out  2  current FSM state, for debug
- `StallCycles`, `FlushCycles`  out  32 each  performance counters; present only with `FETCH_PERF_EN`

## Operation
- Per-cycle priority, highest first: Reset > redirect (`MEM_PCSrc`≠00) > flush > stall > sequential.
- Reset: `IF_PC`=`RESET_PC`; `ID_Instruction`=`NOP_WORD`; `ID_PCPlus4`=0; `ID_Valid`=0; state RUN; counters 0.
- Redirect:
  - `IF_PC` loads the selected target with bits [1:0] forced to 00.
  - IF/ID loads a bubble: `NOP_WORD`, PC+4=0, valid 0.
  - State goes to REDIRECT.
  - Redirect overrides `ID_Stall` and `Flush_IF_ID`.
- Flush without redirect: IF/ID loads a bubble. If `ID_Stall` is also high, `IF_PC` holds; otherwise `IF_PC` advances by 4. State goes to STALL if stalled, otherwise RUN.
- Stall without flush or redirect: `IF_PC` and IF/ID hold their values bit-for-bit. State goes to STALL.
- Sequential: `IF_PC` <= `IF_PC`+4; IF/ID <= {`IM_Instruction`, `IF_PC`+4, valid 1}; state goes to RUN.
- FSM states:
  - RUN=00: normal issue.
  - STALL=01: holding.
  - REDIRECT=10: first fetch after a redirect.
  - REDIRECT always leaves after one cycle. Next state follows the priority list above, so a back-to-back redirect stays in REDIRECT.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- `IF_PC` is registered. `ID_Instruction` for a given `IF_PC` appears one cycle later.
- Redirect seen at edge N: `IF_PC`=target after N; the target's instruction is in IF/ID after N+1.
- Stall released at edge N: fetch resumes at the held `IF_PC`, and no instruction is lost or duplicated.
- Reset asserted mid-stall or mid-redirect wins at the next edge; no pending redirect survives it.
- Inputs are sampled only at the rising edge. Combinational glitches on `ID_Stall` or `Flush_IF_ID` have no effect.

## Configuration
- `FETCH_PERF_EN` defined:
  - `StallCycles` increments on every edge where the stall branch is taken (`ID_Stall`=1, no redirect, not in reset).
  - `FlushCycles` increments on every edge where IF/ID loads a bubble, whether from flush or redirect.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- `FETCH_PERF_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - state encodings RUN/STALL/REDIRECT
  - `MEM_PCSrc` encodings SEQ/BR/JMP/JR
  - default `NOP_WORD` constant
- Sub-module `if_id_reg`: the 65-bit IF/ID register {instr, pcplus4, valid} with `hold` and `bubble` controls; `bubble` wins over `hold`.
- Top level holds the PC register, target mux, FSM and optional counters.

## Test plan
- Reset then 4 free-running cycles with memory returning 32'h1111_0000+PC:
  - `IF_PC` = 0, 4, 8, C
  - `ID_Instruction` lags one cycle
  - `ID_Valid` goes 1 after the first edge
- `ID_Stall` high 3 cycles with `IF_PC`=8:
  - `IF_PC` stays 8 and IF/ID is frozen
  - after release the next issued word is the one for PC 8
  - `StallCycles`=3
- `ID_Stall` and `Flush_IF_ID` high together for 2 cycles: `IF_PC` holds, `ID_Valid`=0, `ID_Instruction`=`NOP_WORD`, `FlushCycles`=2.
- `MEM_PCSrc`=01 with `BranchTarget`=32'h40 while `ID_Stall`=1:
  - `IF_PC`=40 next cycle and `FetchState`=REDIRECT
  - a bubble is in IF/ID, and the word for 40 is in IF/ID one cycle later
- `MEM_PCSrc`=11 with `JrTarget`=32'h0000_0103: `IF_PC`=32'h0000_0100.
- `IF_PC`=32'hFFFF_FFFC free-running: next `IF_PC`=0, and `ID_PCPlus4`=0 with `ID_Valid`=1.
- Reset asserted during REDIRECT: next edge gives `IF_PC`=`RESET_PC`, state RUN, `ID_Valid`=0.
